// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
//   state_t        : arbiter FSM states
//   MST_CORE/AUX   : master identifiers as carried on grant_id
//   *_DEF          : default widths and latency for the arbiter parameters
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic MST_CORE = 1'b0;
    localparam logic MST_AUX  = 1'b1;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int READ_LATENCY_DEF = 1;
    localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin winner select (purely combinational).
//   req        in  {m1_req, m0_req}
//   last_grant in  master that won the previous arbitration
//   winner     out master that wins now (only meaningful when any_req=1)
//   any_req    out at least one request is pending
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = MST_CORE;
        case (req)
            2'b01:   winner = MST_CORE;
            2'b10:   winner = MST_AUX;
            // Tie goes to whoever did not win last time.
            2'b11:   winner = ~last_grant;
            default: winner = MST_CORE;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises accesses from two masters onto one synchronous memory port.
// One transaction at a time, round-robin on ties, registered memory outputs,
// fixed read latency, one-cycle ack pulse back to the winning master.
//   clk, resetn             clock and async active-low reset
//   m0_* / m1_*             master ports: req/we/addr/wdata in, ack/rdata out
//   mem_address/data_out/we registered memory request
//   mem_data_in             memory read data, valid READ_LATENCY edges after address
//   busy                    high whenever the FSM is not in IDLE
//   grant_id                owner of the current or most recent transaction
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's command
// ACCESS | memory access in flight (write: one cycle, read: READ_LATENCY cycles)
// RESP   | ack pulse to the winner; requests ignored
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              busy,
    output logic              grant_id
);

    // Read wait is a down-counter: loaded at grant, completes when it hits zero.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              grant_id_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_data_out_nxt;
    logic              mem_we_nxt;
    logic              m0_ack_nxt, m1_ack_nxt;
    logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
    logic              winner, any_req;
    logic              access_done;

    rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // mem_we is only ever high during the ACCESS cycle of a write.
    assign access_done = mem_we || (cnt == '0);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            last_grant   <= MST_AUX;
            grant_id     <= MST_CORE;
            cnt          <= '0;
            mem_address  <= '0;
            mem_data_out <= '0;
            mem_we       <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            grant_id     <= grant_id_nxt;
            cnt          <= cnt_nxt;
            mem_address  <= mem_address_nxt;
            mem_data_out <= mem_data_out_nxt;
            mem_we       <= mem_we_nxt;
            m0_ack       <= m0_ack_nxt;
            m1_ack       <= m1_ack_nxt;
            m0_rdata     <= m0_rdata_nxt;
            m1_rdata     <= m1_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_grant_nxt   = last_grant;
        grant_id_nxt     = grant_id;
        cnt_nxt          = cnt;
        mem_address_nxt  = mem_address;
        mem_data_out_nxt = mem_data_out;
        mem_we_nxt       = 1'b0;
        m0_ack_nxt       = 1'b0;
        m1_ack_nxt       = 1'b0;
        m0_rdata_nxt     = m0_rdata;
        m1_rdata_nxt     = m1_rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_id_nxt   = winner;
                    last_grant_nxt = winner;
                    cnt_nxt        = LAT_LOAD;
                    if (winner == MST_AUX) begin
                        mem_address_nxt  = m1_addr;
                        mem_data_out_nxt = m1_wdata;
                        mem_we_nxt       = m1_we;
                    end else begin
                        mem_address_nxt  = m0_addr;
                        mem_data_out_nxt = m0_wdata;
                        mem_we_nxt       = m0_we;
                    end
                end
            end
            ACCESS: begin
                if (access_done) begin
                    if (grant_id == MST_AUX) begin
                        m1_ack_nxt = 1'b1;
                        if (!mem_we) m1_rdata_nxt = mem_data_in;
                    end else begin
                        m0_ack_nxt = 1'b1;
                        if (!mem_we) m0_rdata_nxt = mem_data_in;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    // Fast instance (READ_LATENCY=1)
    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_address, mem_data_out, mem_data_in;
    logic        mem_we, busy, grant_id;

    // Slow instance (READ_LATENCY=3)
    logic        s_m0_req, s_m0_we, s_m0_ack, s_m1_req, s_m1_we, s_m1_ack;
    logic [31:0] s_m0_addr, s_m0_wdata, s_m0_rdata, s_m1_addr, s_m1_wdata, s_m1_rdata;
    logic [31:0] s_mem_address, s_mem_data_out, s_mem_data_in;
    logic        s_mem_we, s_busy, s_grant_id;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
        .mem_data_in(mem_data_in), .busy(busy), .grant_id(grant_id)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .CNT_W(4)) dut_slow (
        .clk(clk), .resetn(resetn),
        .m0_req(s_m0_req), .m0_we(s_m0_we), .m0_addr(s_m0_addr), .m0_wdata(s_m0_wdata),
        .m0_ack(s_m0_ack), .m0_rdata(s_m0_rdata),
        .m1_req(s_m1_req), .m1_we(s_m1_we), .m1_addr(s_m1_addr), .m1_wdata(s_m1_wdata),
        .m1_ack(s_m1_ack), .m1_rdata(s_m1_rdata),
        .mem_address(s_mem_address), .mem_data_out(s_mem_data_out), .mem_we(s_mem_we),
        .mem_data_in(s_mem_data_in), .busy(s_busy), .grant_id(s_grant_id)
    );

    // Memory model: the arbiter's address register acts as the RAM address
    // register, so one edge of latency means a direct read of mem_address.
    // Extra latency is modelled with output pipeline stages.
    logic [31:0] mem [0:255];
    logic [31:0] s_p1, s_p2;

    always @(posedge clk) begin
        if (mem_we)   mem[mem_address[7:0]]   <= mem_data_out;
        if (s_mem_we) mem[s_mem_address[7:0]] <= s_mem_data_out;
    end
    assign mem_data_in = mem[mem_address[7:0]];

    always @(posedge clk) begin
        s_p1 <= mem[s_mem_address[7:0]];
        s_p2 <= s_p1;
    end
    assign s_mem_data_in = s_p2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req0, req1, we0, we1;
        logic [31:0] addr0, addr1, wd0, wd1;
        logic        exp_gnt;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_rd0, exp_rd1;

    // One transaction from IDLE; latency counted in negedges after the drive.
    task automatic run_vec(input vec_t v);
        int          lat;
        logic        w;
        logic [31:0] a, d;
        w = v.exp_gnt ? v.we1   : v.we0;
        a = v.exp_gnt ? v.addr1 : v.addr0;
        d = v.exp_gnt ? v.wd1   : v.wd0;
        m0_req = v.req0; m0_we = v.we0; m0_addr = v.addr0; m0_wdata = v.wd0;
        m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr1; m1_wdata = v.wd1;
        @(negedge clk);
        chk("vec_grant_id", 32'(grant_id), 32'(v.exp_gnt));
        chk("vec_busy", 32'(busy), 32'd1);
        chk("vec_mem_address", mem_address, a);
        chk("vec_mem_we", 32'(mem_we), 32'(w));
        if (w) chk("vec_mem_data_out", mem_data_out, d);
        lat = 1;
        while (!(m0_ack | m1_ack) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("vec_latency", 32'(lat), 32'(v.exp_lat));
        chk("vec_ack_id", 32'({m1_ack, m0_ack}), v.exp_gnt ? 32'd2 : 32'd1);
        chk("vec_mem_we_off", 32'(mem_we), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        if (!w) begin
            if (v.exp_gnt) exp_rd1 = v.exp_rdata;
            else           exp_rd0 = v.exp_rdata;
        end
        chk("vec_m0_rdata", m0_rdata, exp_rd0);
        chk("vec_m1_rdata", m1_rdata, exp_rd1);
        @(negedge clk);
        chk("vec_ack_clear", 32'({m1_ack, m0_ack}), 32'd0);
        chk("vec_busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acks;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h0BAD_F00D;
        mem[8'h08] = 32'h8888_8888;
        mem[8'h0C] = 32'hCCCC_CCCC;
        mem[8'h10] = 32'hDEAD_BEEF;

        vecs[0] = '{req0:1'b1, req1:1'b0, we0:1'b0, we1:1'b0, addr0:32'h10, addr1:32'h0,
                    wd0:32'h0, wd1:32'h0, exp_gnt:1'b0, exp_rdata:32'hDEAD_BEEF, exp_lat:2};
        vecs[1] = '{req0:1'b0, req1:1'b1, we0:1'b0, we1:1'b1, addr0:32'h0, addr1:32'h20,
                    wd0:32'h0, wd1:32'h1234_5678, exp_gnt:1'b1, exp_rdata:32'h0, exp_lat:2};
        vecs[2] = '{req0:1'b0, req1:1'b1, we0:1'b0, we1:1'b0, addr0:32'h0, addr1:32'h20,
                    wd0:32'h0, wd1:32'h0, exp_gnt:1'b1, exp_rdata:32'h1234_5678, exp_lat:2};
        vecs[3] = '{req0:1'b1, req1:1'b1, we0:1'b1, we1:1'b0, addr0:32'h30, addr1:32'h10,
                    wd0:32'hAAAA_5555, wd1:32'h0, exp_gnt:1'b0, exp_rdata:32'h0, exp_lat:2};
        vecs[4] = '{req0:1'b1, req1:1'b1, we0:1'b0, we1:1'b0, addr0:32'h30, addr1:32'h10,
                    wd0:32'h0, wd1:32'h0, exp_gnt:1'b1, exp_rdata:32'hDEAD_BEEF, exp_lat:2};
        vecs[5] = '{req0:1'b1, req1:1'b1, we0:1'b0, we1:1'b1, addr0:32'h30, addr1:32'h40,
                    wd0:32'h0, wd1:32'h55, exp_gnt:1'b0, exp_rdata:32'hAAAA_5555, exp_lat:2};

        resetn = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_m0_req = 0; s_m0_we = 0; s_m0_addr = 0; s_m0_wdata = 0;
        s_m1_req = 0; s_m1_we = 0; s_m1_addr = 0; s_m1_wdata = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data_out", mem_data_out, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);

        // Continuous contention from the first cycle after reset
        resetn = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h04;
        for (int k = 0; k < 8; k++) begin
            lat = 0;
            while (!(m0_ack | m1_ack) && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("cont_ack_id", 32'({m1_ack, m0_ack}), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk("cont_grant_id", 32'(grant_id), 32'(k % 2));
            if (k % 2 == 1) chk("cont_m1_rdata", m1_rdata, 32'h0BAD_F00D);
            else            chk("cont_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
            if (k == 7) begin m0_req = 0; m1_req = 0; end
            @(negedge clk);
        end
        exp_rd0 = 32'hDEAD_BEEF;
        exp_rd1 = 32'h0BAD_F00D;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Address change and req drop after grant
        m0_req = 1; m0_we = 0; m0_addr = 32'h08;
        @(negedge clk);
        chk("chg_mem_address_grant", mem_address, 32'h08);
        m0_addr = 32'h0C; m0_req = 0;
        @(negedge clk);
        chk("chg_ack_id", 32'({m1_ack, m0_ack}), 32'd1);
        chk("chg_m0_rdata", m0_rdata, 32'h8888_8888);
        chk("chg_mem_address_hold", mem_address, 32'h08);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acks += int'(m0_ack) + int'(m1_ack);
        end
        chk("chg_no_extra_ack", 32'(acks), 32'd0);

        // Async reset in the middle of an m1 read
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        @(negedge clk);
        chk("arst_pre_busy", 32'(busy), 32'd1);
        chk("arst_pre_grant", 32'(grant_id), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd0);
        chk("arst_mem", 32'({mem_we, |mem_address, |mem_data_out}), 32'd0);
        chk("arst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        chk("arst_m1_rdata", m1_rdata, 32'd0);
        chk("arst_m0_rdata", m0_rdata, 32'd0);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            acks += int'(m0_ack) + int'(m1_ack);
        end
        chk("arst_no_ack", 32'(acks), 32'd0);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1;
        resetn = 1'b1;
        @(negedge clk);
        chk("arst_first_grant", 32'(grant_id), 32'd0);
        chk("arst_first_busy", 32'(busy), 32'd1);
        m0_req = 0; m1_req = 0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("arst_settled_busy", 32'(busy), 32'd0);

        // READ_LATENCY=3 instance
        s_m0_req = 1; s_m0_we = 0; s_m0_addr = 32'h04;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) chk("slow_mem_address", s_mem_address, 32'h04);
            chk("slow_busy", 32'(s_busy), (c <= 4) ? 32'd1 : 32'd0);
            chk("slow_ack", 32'({s_m1_ack, s_m0_ack}), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) begin
                chk("slow_m0_rdata", s_m0_rdata, 32'h0BAD_F00D);
                s_m0_req = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
